// File: rtl/mmu_pkg.sv
// Shared MMU types and sizing helpers, used by the array, the input skew feeder
// and the result de-skew collector.
package mmu_pkg;
  localparam int ACC_WIDTH = 16;
  localparam int SIZE      = 16;

  typedef logic [ACC_WIDTH-1:0] acc_t;
  typedef acc_t [SIZE-1:0]      acc_row_t;

  // Occupancy width: one bit more than the address so a full FIFO reads DEPTH.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/mmu_result_deskew_if.sv
// Downstream row handshake of the result collector: show-ahead row, valid/ready,
// and FIFO occupancy.
interface mmu_result_deskew_if #(
  parameter int W  = mmu_pkg::SIZE * mmu_pkg::ACC_WIDTH,
  parameter int CW = 4
);
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] fifo_count;

  modport master (output out_valid, out_data, fifo_count, input out_ready);
  modport slave  (input out_valid, out_data, fifo_count, output out_ready);
endinterface

// File: rtl/mmu_result_fifo.sv
// Show-ahead FIFO of aligned rows. Pointers carry an extra wrap bit to tell full
// from empty; a push into a full FIFO is taken only when a pop frees the head slot.
module mmu_result_fifo #(
  parameter int W     = 256,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);
  import mmu_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wptr, r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_pop, w_push;

  assign empty  = (r_wptr == r_rptr);
  assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign count  = r_wptr - r_rptr;
  assign head   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // When full, the write slot equals the head slot being popped this edge.
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= push_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/mmu_result_deskew.sv
// Re-aligns the time-skewed column results of the MMU into whole rows and queues
// them for the writeback stage. The array cannot stall, so full drops a row.
module mmu_result_deskew #(
  parameter int ACC_WIDTH  = mmu_pkg::ACC_WIDTH,
  parameter int SIZE       = mmu_pkg::SIZE,
  parameter int PIPE_LAT   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      row_valid_in,
  input  logic [SIZE*ACC_WIDTH-1:0] acc_in,
  output logic                      overflow,
  input  logic                      clear_ovf,
  mmu_result_deskew_if.master       out_if
);
  import mmu_pkg::*;

  localparam int W    = SIZE * ACC_WIDTH;
  localparam int TAPS = PIPE_LAT + SIZE - 1;

  logic [TAPS:1] r_vld_pipe;
  logic [W-1:0]  w_row;
  logic          w_push, w_full, w_empty, w_drop;
  logic          r_ovf;

  // Tap k is high when a row entered column 0 k edges ago.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_vld_pipe <= '0;
    else begin
      r_vld_pipe[1] <= row_valid_in;
      for (int k = 2; k <= TAPS; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
    end
  end

  // Column j is delayed SIZE-1-j edges so every column of a row lines up with
  // the last column, which is taken straight from the array.
  for (genvar j = 0; j < SIZE; j++) begin : g_col
    if (j == SIZE-1) begin : g_live
      assign w_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_in[j*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      localparam int N = SIZE - 1 - j;
      logic [ACC_WIDTH-1:0] r_dl [N];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < N; s++) r_dl[s] <= '0;
        end else begin
          r_dl[0] <= acc_in[j*ACC_WIDTH +: ACC_WIDTH];
          for (int s = 1; s < N; s++) r_dl[s] <= r_dl[s-1];
        end
      end
      assign w_row[j*ACC_WIDTH +: ACC_WIDTH] = r_dl[N-1];
    end
  end

  assign w_push = r_vld_pipe[TAPS];
  assign w_drop = w_push && w_full && !(out_if.out_ready && !w_empty);

  mmu_result_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_row),
    .pop       (out_if.out_ready),
    .full      (w_full),
    .empty     (w_empty),
    .count     (out_if.fifo_count),
    .head      (out_if.out_data)
  );

  assign out_if.out_valid = !w_empty;

  // A drop in the same cycle as clear_ovf keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (clear_ovf) r_ovf <= 1'b0;
  end

  assign overflow = r_ovf;
endmodule

// File: doc/mmu_result_deskew.md
Name: mmu_result_deskew

Overview:
- Collector at the output end of the weight-stationary MMU.
- The array emits column results skewed in time: column j of data row r exits one cycle later than column j-1.
- This block samples each column at its skewed instant and re-aligns the row into one wide word. It then buffers rows in a FIFO and presents them downstream on a valid/ready handshake.
- It sits between MMU acc_out_final and the accumulator/writeback stage. It is the counterpart of the skewed data feed into the array.

Parameters:
- ACC_WIDTH, 16, width of one accumulator result.
- SIZE, 16, array dimension (number of columns).
- PIPE_LAT, 16, cycles from a row's row_valid_in to column 0's result on acc_in. Must be ≥1.
- FIFO_DEPTH, 8, aligned rows buffered. Power of two, ≥2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset. Low clears all state.
- row_valid_in  in  1  pulse per data row, high in the cycle that row enters column 0 of the array (unskewed time).
- acc_in  in  SIZE*ACC_WIDTH  MMU acc_out_final. Column j occupies bits [j*ACC_WIDTH +: ACC_WIDTH].
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts when high together with out_valid.
- out_data  out  SIZE*ACC_WIDTH  aligned row, same column packing as acc_in. FIFO head, show-ahead.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  rows held.
- overflow  out  1  sticky: a row was dropped.
- clear_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset values (reset low, asynchronous):
  - out_valid=0, fifo_count=0, overflow=0, out_data=0.
  - Valid tracker, delay lines and FIFO pointers all cleared.
- Valid tracker:
  - Shift register of length PIPE_LAT+SIZE-1, fed by row_valid_in.
  - Tap k is high when a row was injected k edges earlier.
- Column capture and de-skew:
  - Column j (j<SIZE-1) feeds a free-running delay line of SIZE-1-j stages.
  - Column SIZE-1 has no stages and is used live.
  - Row injected at edge T: column j is captured at edge T+PIPE_LAT+j.
  - At edge E=T+PIPE_LAT+SIZE-1, all columns of that row are simultaneously present at the delay-line outputs.
- FIFO push:
  - Push at edge E when tap PIPE_LAT+SIZE-1 is high.
  - out_valid rises in the cycle after E. Latency from row_valid_in to out_valid is PIPE_LAT+SIZE cycles.
  - Back-to-back rows (row_valid_in high every cycle) yield one push per cycle, with no gaps or reordering.
- Pop: occurs on the edge where out_valid & out_ready. out_data updates to the next entry after the pop edge.
- Full handling:
  - The array cannot stall, so a push is never back-pressured.
  - Full with simultaneous pop: push accepted, count unchanged.
  - Full without pop: row dropped, FIFO unchanged, overflow set at that edge.
- Empty handling: out_ready while empty has no effect. Pointers never underflow.
- Simultaneous push and pop when not full: count unchanged; data order preserved.
- Pointers wrap modulo FIFO_DEPTH. An extra MSB distinguishes full from empty.
- overflow:
  - Set dominates clear_ovf in the same cycle.
  - Otherwise clear_ovf drops it at the next edge.
- Reset mid-operation: rows in flight in the delay lines and FIFO are discarded. No spurious push after reset release.
- Arithmetic: none. Data is passed bit-exact; no width change.

Decomposition:
- Package mmu_pkg: ACC_WIDTH, SIZE constants; typedef acc_t (logic [ACC_WIDTH-1:0]); typedef acc_row_t (acc_t [SIZE-1:0]). Shared with MMU and the input skew feeder.
- Sub-module mmu_result_fifo: synchronous show-ahead FIFO with push/pop/full/empty/count.
- Delay lines and the valid tracker stay in the top level (generate loop).

Test Plan:
- Single row, SIZE=4, PIPE_LAT=4:
  - Stimulus: row_valid_in pulse at cycle 0; bench drives column j = 16'h0100+j at cycle 4+j, garbage otherwise.
  - Response: out_valid rises at cycle 8 with out_data = {0103,0102,0101,0100}; fifo_count=1.
- Four back-to-back rows, out_ready=1:
  - Stimulus: row r column j = 16'h0100*(r+1)+j.
  - Response: out_valid high cycles 8–11; rows emerge in order 0–3, each correctly aligned.
- Fill, SIZE=4, FIFO_DEPTH=8, out_ready=0:
  - 8 rows → fifo_count=8, overflow=0.
  - 9th row → dropped, overflow=1, contents unchanged.
  - clear_ovf → overflow=0.
- Full with simultaneous push+pop at the same edge: count stays 8, overflow stays 0, popped row is row 0, new row is appended last.
- Reset asserted low while 3 rows are in flight and 2 are buffered: immediately out_valid=0, fifo_count=0. After release with no stimulus, out_valid stays 0 for 20 cycles.
- Random out_ready (50%), 100 rows at ≤1 row per 2 cycles: all rows received in order, bit-exact against the model, no overflow.
